// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
package pc_seq_pkg;

    // Encodings are visible on state_dbg, so they are fixed explicitly.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam int TIMEOUT_DEF = 16;
    localparam int INSTR_W_DEF = 32;

    // Wait counter width; kept at least 1 bit so TIMEOUT=0 still elaborates.
    function automatic int cnt_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Memory/decoder/PC-strobe bundle between the sequencer and its neighbours.
interface pc_sequencer_if #(parameter int INSTR_W = 32);
    logic               en;
    logic [INSTR_W-1:0] instr_in;
    logic               imem_ack;
    logic               dmem_ack;
    logic               is_branch;
    logic               is_jump;
    logic               is_mem;
    logic               is_halt;
    logic               wb_en;
    logic               branch_taken;
    logic               imem_req;
    logic               dmem_req;
    logic [INSTR_W-1:0] instr_out;
    logic               pc_inc;
    logic               pc_load;
    logic               pc_disable;
    logic               pc_branch;
    logic               regfile_we;
    logic [31:0]        instret;
    logic               fault;
    logic [2:0]         state_dbg;

    // Sequencer side.
    modport master (
        input  en, instr_in, imem_ack, dmem_ack, is_branch, is_jump, is_mem,
               is_halt, wb_en, branch_taken,
        output imem_req, dmem_req, instr_out, pc_inc, pc_load, pc_disable,
               pc_branch, regfile_we, instret, fault, state_dbg
    );

    // Memory / decoder / PC side.
    modport slave (
        output en, instr_in, imem_ack, dmem_ack, is_branch, is_jump, is_mem,
               is_halt, wb_en, branch_taken,
        input  imem_req, dmem_req, instr_out, pc_inc, pc_load, pc_disable,
               pc_branch, regfile_we, instret, fault, state_dbg
    );
endinterface

// File: rtl/pc_sequencer_wait_timer.sv
// Memory wait counter: cleared on any state change, flags the last allowed cycle.
module wait_timer
    import pc_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int CW = cnt_w(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (count)
            cnt_d = cnt_q + CW'(1);
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clr)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Expiry means this is the TIMEOUT-th waiting cycle; TIMEOUT=0 never expires.
    always_comb begin
        expired = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
    end
endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle sequencer driving the PC control strobes for an RV32I core.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic            clk,
    input  logic            clr,
    pc_sequencer_if.master  bus
);
    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        instret_q, instret_d;
    logic               fault_q, fault_d;
    logic               tmr_clear, tmr_exp;
    logic               imem_req, dmem_req, pc_inc, pc_load, pc_disable;
    logic               pc_branch, regfile_we, taken;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .clr     (clr),
        .clear   (tmr_clear),
        .count   (!tmr_clear),
        .expired (tmr_exp)
    );

    // Next state plus strobe decode; PC held by pc_disable outside UPDATE.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instret_d  = instret_q;
        fault_d    = fault_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_disable = 1'b1;
        pc_branch  = 1'b0;
        regfile_we = 1'b0;
        taken      = bus.is_jump | (bus.is_branch & bus.branch_taken);
        case (state_q)
            S_IDLE: if (bus.en) state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    instr_d = bus.instr_in;
                    state_d = S_EXEC;
                end else if (tmr_exp) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                if (bus.is_halt)     state_d = S_HALT;
                else if (bus.is_mem) state_d = S_MEM;
                else                 state_d = S_UPDATE;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (bus.dmem_ack) begin
                    state_d = S_UPDATE;
                end else if (tmr_exp) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end
            end
            S_UPDATE: begin
                // Not-taken must increment: load with pc_branch=0 would freeze the PC.
                pc_disable = 1'b0;
                pc_load    = taken;
                pc_branch  = taken;
                pc_inc     = !taken;
                regfile_we = bus.wb_en;
                instret_d  = instret_q + 32'd1;
                state_d    = bus.en ? S_FETCH : S_IDLE;
            end
            S_HALT, S_FAULT: state_d = state_q;
            default: state_d = S_IDLE;
        endcase
        tmr_clear = (state_d != state_q);
    end

    // Architectural registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            instret_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.dmem_req   = dmem_req;
    assign bus.instr_out  = instr_q;
    assign bus.pc_inc     = pc_inc;
    assign bus.pc_load    = pc_load;
    assign bus.pc_disable = pc_disable;
    assign bus.pc_branch  = pc_branch;
    assign bus.regfile_we = regfile_we;
    assign bus.instret    = instret_q;
    assign bus.fault      = fault_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a scoreboard checked in UPDATE cycles.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.INSTR_W(32)) bus();

    pc_sequencer #(.TIMEOUT(16), .INSTR_W(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    typedef struct {
        logic        inc;
        logic        load;
        logic        br;
        logic        we;
        logic [31:0] cnt;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cnt = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [2:0] s, input string nm);
        chk(nm, {29'd0, bus.state_dbg}, {29'd0, s});
    endtask

    // Monitor: strobe one-hot check every cycle, scoreboard pop on UPDATE.
    exp_t e;
    always @(negedge clk) begin
        chk("onehot", $countones({bus.pc_inc, bus.pc_load, bus.pc_disable}), 32'd1);
        if (bus.state_dbg == 3'd4) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got update cycle want none");
            end else begin
                e = sb.pop_front();
                chk("upd_inc",   bus.pc_inc,     e.inc);
                chk("upd_load",  bus.pc_load,    e.load);
                chk("upd_br",    bus.pc_branch,  e.br);
                chk("upd_we",    bus.regfile_we, e.we);
                chk("upd_cnt",   bus.instret,    e.cnt);
                chk("upd_instr", bus.instr_out,  e.ins);
            end
        end
    end

    task automatic clear_dec();
        bus.is_branch = 0; bus.is_jump = 0; bus.is_mem = 0; bus.is_halt = 0;
        bus.wb_en = 0; bus.branch_taken = 0; bus.imem_ack = 0; bus.dmem_ack = 0;
    endtask

    // Non-memory instruction with immediate imem_ack: FETCH, EXEC, UPDATE, then IDLE.
    task automatic run_simple(input logic [31:0] ins, input logic br, input logic bt,
                              input logic jmp, input logic wb, input logic x_inc,
                              input logic x_load, input logic x_we);
        bus.instr_in = ins; bus.is_branch = br; bus.branch_taken = bt;
        bus.is_jump = jmp; bus.wb_en = wb; bus.imem_ack = 1; bus.en = 1;
        sb.push_back('{x_inc, x_load, x_load, x_we, exp_cnt, ins});
        exp_cnt++;
        cyc(); st(3'd1, "s_fetch");
        cyc(); st(3'd2, "s_exec");
        cyc(); st(3'd4, "s_update");
        bus.en = 0;
        cyc(); st(3'd0, "s_idle");
        chk("instret", bus.instret, exp_cnt);
        chk("instr_out", bus.instr_out, ins);
        clear_dec();
    endtask

    // Memory instruction: MEM lasts waits+1 cycles; optionally drop en in first MEM cycle.
    task automatic run_mem(input logic [31:0] ins, input int waits, input logic wb,
                           input logic drop_en);
        bus.instr_in = ins; bus.is_mem = 1; bus.wb_en = wb; bus.imem_ack = 1; bus.en = 1;
        sb.push_back('{1'b1, 1'b0, 1'b0, wb, exp_cnt, ins});
        exp_cnt++;
        cyc(); st(3'd1, "m_fetch");
        cyc(); st(3'd2, "m_exec");
        cyc();
        for (int i = 0; i <= waits; i++) begin
            st(3'd3, "m_mem");
            chk("dmem_req", bus.dmem_req, 1);
            if (i == 0 && drop_en) bus.en = 0;
            if (i == waits) bus.dmem_ack = 1;
            cyc();
        end
        st(3'd4, "m_update");
        bus.dmem_ack = 0; bus.en = 0;
        cyc(); st(3'd0, "m_idle");
        chk("m_instret", bus.instret, exp_cnt);
        clear_dec();
    endtask

    initial begin
        bus.en = 0; bus.instr_in = 0;
        clear_dec();
        clr = 0;
        cyc(); cyc();
        st(3'd0, "rst_state");
        chk("rst_instr", bus.instr_out, 0);
        chk("rst_cnt", bus.instret, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_imem_req", bus.imem_req, 0);
        clr = 1;

        run_simple(32'h00500093, 0, 0, 0, 1, 1, 0, 1);  // addi, writes rd
        run_simple(32'h00208463, 1, 1, 0, 0, 0, 1, 0);  // beq taken
        run_simple(32'h00208463, 1, 0, 0, 0, 1, 0, 0);  // beq not taken
        run_simple(32'h008000ef, 0, 0, 1, 1, 0, 1, 1);  // jal

        run_mem(32'h0000a103, 3, 1, 0);  // lw, 3 wait cycles: 7 cycles total
        run_mem(32'h0020a023, 1, 0, 1);  // sw with en dropped in MEM

        // Reset in FETCH abandons the request.
        bus.instr_in = 32'hdeadbeef; bus.en = 1;
        cyc(); st(3'd1, "r_fetch");
        clr = 0; bus.en = 0;
        cyc(); clr = 1;
        st(3'd0, "r_idle");
        chk("r_instr", bus.instr_out, 0);
        chk("r_cnt", bus.instret, 0);
        chk("r_imem_req", bus.imem_req, 0);
        chk("r_disable", bus.pc_disable, 1);
        exp_cnt = 0;

        // Halt holds with PC disabled and no retire.
        run_simple(32'h00500093, 0, 0, 0, 1, 1, 0, 1);
        bus.instr_in = 32'h00100073; bus.is_halt = 1; bus.imem_ack = 1; bus.en = 1;
        cyc(); st(3'd1, "h_fetch");
        cyc(); st(3'd2, "h_exec");
        cyc();
        for (int i = 0; i < 100; i++) begin
            st(3'd5, "h_halt");
            chk("h_disable", bus.pc_disable, 1);
            chk("h_cnt", bus.instret, exp_cnt);
            cyc();
        end
        clr = 0; bus.en = 0; clear_dec();
        cyc(); clr = 1;
        st(3'd0, "h_rst");
        exp_cnt = 0;

        // Timeout: 16 FETCH cycles without imem_ack, dmem_ack must not help.
        bus.en = 1; bus.dmem_ack = 1;
        cyc();
        for (int i = 0; i < 16; i++) begin
            st(3'd1, "t_fetch");
            chk("t_fault", bus.fault, 0);
            cyc();
        end
        st(3'd6, "t_state");
        chk("t_fault_set", bus.fault, 1);
        bus.imem_ack = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            st(3'd6, "t_hold");
            chk("t_fault_hold", bus.fault, 1);
            chk("t_imem_req", bus.imem_req, 0);
        end
        clr = 0; bus.en = 0; clear_dec();
        cyc(); clr = 1;
        st(3'd0, "t_rst");
        chk("t_rst_fault", bus.fault, 0);
        chk("t_rst_cnt", bus.instret, 0);

        cyc();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
